// File: rtl/mc_seq.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the RV32I subset core.
// Shares one memory port between instruction fetch and data access.
module mc_seq (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] Op,
   input  logic [6:0] Funct7,
   input  logic [2:0] Funct3,
   input  logic       Zero,
   input  logic       mem_ready,
   output logic       MemReq,
   output logic       MemWrite,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MDRWrite,
   output logic       RegWrite,
   output logic [1:0] WDSel,
   output logic       PCWrite,
   output logic [2:0] NPCOp,
   output logic       illegal,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   state_t r_state;
   state_t w_next;

   logic w_is_alu;
   logic w_is_load;
   logic w_is_store;
   logic w_is_branch;
   logic w_is_jal;
   logic w_is_jalr;
   logic w_legal;

   always_comb begin
      w_is_alu    = 1'b0;
      w_is_load   = 1'b0;
      w_is_store  = 1'b0;
      w_is_branch = 1'b0;
      w_is_jal    = 1'b0;
      w_is_jalr   = 1'b0;
      case (Op)
         7'b0110011: w_is_alu    = (Funct3 == 3'b000) &&
                                   ((Funct7 == 7'b0000000) || (Funct7 == 7'b0100000));
         7'b0010011: w_is_alu    = (Funct3 == 3'b000);
         7'b0000011: w_is_load   = (Funct3 <= 3'b010);
         7'b0100011: w_is_store  = (Funct3 <= 3'b010);
         7'b1100011: w_is_branch = (Funct3 != 3'b010) && (Funct3 != 3'b011);
         7'b1101111: w_is_jal    = 1'b1;
         7'b1100111: w_is_jalr   = 1'b1;
         default:    ;
      endcase
      w_legal = w_is_alu | w_is_load | w_is_store | w_is_branch | w_is_jal | w_is_jalr;
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      MemReq   = 1'b0;
      MemWrite = 1'b0;
      IorD     = 1'b0;
      IRWrite  = 1'b0;
      MDRWrite = 1'b0;
      RegWrite = 1'b0;
      WDSel    = 2'b00;
      PCWrite  = 1'b0;
      NPCOp    = 3'b000;
      case (r_state)
         S_FETCH: begin
            MemReq = 1'b1;
            if (mem_ready) begin
               IRWrite = 1'b1;
               w_next  = S_DECODE;
            end
         end
         S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
         S_EXEC: begin
            if (w_is_alu) begin
               w_next = S_WB;
            end else if (w_is_load || w_is_store) begin
               w_next = S_MEM;
            end else if (w_is_branch) begin
               PCWrite = 1'b1;
               NPCOp   = Zero ? 3'b001 : 3'b000;
               w_next  = S_FETCH;
            end else if (w_is_jal || w_is_jalr) begin
               RegWrite = 1'b1;
               WDSel    = 2'b10;
               PCWrite  = 1'b1;
               NPCOp    = w_is_jal ? 3'b010 : 3'b100;
               w_next   = S_FETCH;
            end else begin
               w_next = S_TRAP;
            end
         end
         S_MEM: begin
            MemReq   = 1'b1;
            IorD     = 1'b1;
            MemWrite = w_is_store;
            if (mem_ready) begin
               if (w_is_store) begin
                  PCWrite = 1'b1;
                  w_next  = S_FETCH;
               end else begin
                  MDRWrite = 1'b1;
                  w_next   = S_WB;
               end
            end
         end
         S_WB: begin
            RegWrite = 1'b1;
            WDSel    = w_is_load ? 2'b01 : 2'b00;
            PCWrite  = 1'b1;
            w_next   = S_FETCH;
         end
         S_TRAP: w_next = S_TRAP;
         default: w_next = S_FETCH;
      endcase
      // Reset overrides the state decode so a pending memory request is withdrawn at once.
      if (rst) begin
         MemReq   = 1'b0;
         MemWrite = 1'b0;
         IorD     = 1'b0;
         IRWrite  = 1'b0;
         MDRWrite = 1'b0;
         RegWrite = 1'b0;
         WDSel    = 2'b00;
         PCWrite  = 1'b0;
         NPCOp    = 3'b000;
      end
   end

   assign illegal = (r_state == S_TRAP);
   assign state   = r_state;

endmodule
